request_encoder: RTL and testbench
==================================

Name: request_encoder

Overview:
- Sequential N-to-log2(N) encoder, the inverse direction of the existing one-hot select decoder.
- Captures single-cycle request pulses on N lines into a pending register.
- Priority-encodes the pending set into a binary index and presents it on a valid/ready output handshake, one index per transfer.
- Sits in front of any consumer that takes a binary select, e.g. an interrupt/event source feeding a dispatcher that drives a decoder.

Parameters:
- N, 4, number of request lines; legal range 2..64.
- IDX_W, $clog2(N), derived localparam, width of the output index; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request pulses; bit i high for one cycle marks one event on line i.
- out_index  output  IDX_W  binary index of the presented request.
- out_valid  output  1  out_index is valid.
- out_ready  input  1  consumer accepts out_index when out_valid && out_ready.
- pending  output  N  registered pending set; excludes the index currently presented.
- overflow  output  1  sticky flag; set when a req bit arrives while its pending bit is already set.

Behaviour:
- Reset (rst=1 at an edge): pending=0, out_index=0, out_valid=0, overflow=0, state=IDLE. Reset dominates all same-cycle req and handshake activity.
- Pending update each cycle: pending_next = (pending & ~take_mask) | req.
  - take_mask is the one-hot of the index loaded into the output register this cycle; zero if nothing is loaded.
  - If req sets a bit that is also taken this cycle, set wins: the bit remains pending, counted as a new event.
- Overflow: set when (req & pending & ~take_mask) != 0; sticky until rst.
- State machine, two states:
  - IDLE: out_valid=0. If pending != 0, load out_index = select(pending), set out_valid=1, take that bit, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: out_valid=1 and out_index held stable until handshake.
    - On handshake with pending != 0: load the next index the same edge (back-to-back, no bubble) and stay in PRESENT.
    - On handshake with pending == 0: clear out_valid, go to IDLE.
    - Without handshake: hold.
- Request for the index currently presented: sets its pending bit again; it will be presented a second time after a later selection.
- Latency: req at edge t → pending at t+1 → out_valid/out_index at t+2 (from IDLE).
- Throughput: one index per cycle while out_ready=1 and pending is non-empty.
- select(), fixed priority: lowest set bit index wins.
- out_valid must never drop without a handshake, except on rst.

Optional Feature:
- Macro: REQUEST_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Register last_idx (reset 0) updates to each loaded index.
  - select() searches from (last_idx+1) mod N upward with wrap, so the first selection after reset starts at index 1.
  - Loads with wrap-around equal to N-1 → next search starts at 0.
- Undefined: fixed lowest-index priority; no last_idx register.

Decomposition:
- Package request_encoder_pkg holds:
  - state typedef (IDLE, PRESENT);
  - a function onehot(idx, N) that builds take_mask.
- One natural sub-module: prio_select, combinational. Inputs are the N-bit vector and a start index; outputs the found index and a found flag. In fixed mode start is tied to 0.
- Top level keeps the pending register, state, output register and overflow.

Test Plan:
- Reset mid-PRESENT: pending=4'b1010, out_valid=1, assert rst → next cycle out_valid=0, pending=0, overflow=0, out_index=0.
- Single event: req=4'b0100 for one cycle, out_ready=1 → out_valid=1 with out_index=2 exactly 2 cycles later for 1 cycle, then IDLE.
- Fixed priority burst: req=4'b1011, out_ready=1 → indices 0,1,3 on consecutive cycles, no bubbles; pending empties.
- Backpressure: req=4'b0110, out_ready=0 for 5 cycles → out_index=1 held stable, pending=4'b0100; raise ready → 1 then 2.
- Set-wins and overflow: with pending=4'b0001, pulse req=4'b0001 → overflow=1 sticky. With index 2 loading on the same cycle as req[2], pending[2] stays 1 and index 2 is presented twice.
- Round robin (macro defined): hold req=4'b1111 every cycle, out_ready=1 → index sequence 1,2,3,0,1,… with no index repeated before all four are served.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// Shared types and helpers for the request encoder: FSM state encoding and
// the one-hot builder used to clear the bit that is loaded for presentation.
package request_encoder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Supports up to 64 lines; callers truncate the result to their width.
    function automatic logic [63:0] onehot(input logic [5:0] idx, input int n);
        logic [63:0] m;
        m = '0;
        if (int'(idx) < n) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/request_encoder_prio_select.sv
// Combinational priority search over a request vector, starting at i_start and
// wrapping; the first set bit at or after i_start wins. Zero latency, no handshake.
module prio_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    int w_pos;

    // Scan from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (i_vec[w_pos]) begin
                o_idx   = IDX_W'(w_pos);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Captures request pulses into a pending set and presents one binary index per
// valid/ready transfer; 2 cycles req->out_valid from idle, holds under backpressure.
// REQUEST_ENCODER_ROUND_ROBIN_EN selects round-robin instead of lowest-index priority.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         pending,
    output logic                 overflow
);

    localparam int IDX_W = $clog2(N);

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_pending;
    logic [N-1:0]     w_take_mask;
    logic [N-1:0]     w_pending_next;
    logic [IDX_W-1:0] r_out_index;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic             w_load;
    logic             r_overflow;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_last_idx;

    assign w_start = (r_last_idx == IDX_W'(N - 1)) ? '0 : r_last_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_idx <= '0;
        end else if (w_load) begin
            r_last_idx <= w_sel_idx;
        end
    end
`else
    assign w_start = '0;
`endif

    prio_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_select (
        .i_vec   (r_pending),
        .i_start (w_start),
        .o_idx   (w_sel_idx),
        .o_found (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load happens on entry from IDLE and on every handshake with work left.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load       = 1'b1;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A new request on the bit being taken wins and stays pending.
    assign w_take_mask    = w_load ? N'(onehot(6'(w_sel_idx), N)) : '0;
    assign w_pending_next = (r_pending & ~w_take_mask) | req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_index <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (w_load) begin
                r_out_index <= w_sel_idx;
            end
            if (|(req & r_pending & ~w_take_mask)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_index = r_out_index;
    assign out_valid = (r_state == PRESENT);
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_request_encoder.sv
// Directed table-driven bench for request_encoder (N=4) plus hand-written
// latency and round-robin sequences.
module tb_request_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] out_index;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;
    logic       overflow;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       ev;
        logic       ci;
        logic [1:0] ei;
        logic [3:0] ep;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    request_encoder #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic rd, input logic ev,
                       input logic ci, input logic [1:0] ei, input logic [3:0] ep, input logic eo);
        vec_t v;
        v.rst = r; v.req = q; v.rdy = rd; v.ev = ev;
        v.ci = ci; v.ei = ei; v.ep = ep; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        int n_seen;
        int exp_idx;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;

`ifndef REQUEST_ENCODER_ROUND_ROBIN_EN
        // rst, req, rdy | valid, chk_idx, idx, pending, overflow (after the edge)
        add(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 4'b0100, 0);   // single event
        add(0, 4'b0000, 1, 1, 1, 2, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b1011, 1, 0, 0, 0, 4'b1011, 0);   // fixed priority burst
        add(0, 4'b0000, 1, 1, 1, 0, 4'b1010, 0);
        add(0, 4'b0000, 1, 1, 1, 1, 4'b1000, 0);
        add(0, 4'b0000, 1, 1, 1, 3, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0110, 0, 0, 0, 0, 4'b0110, 0);   // backpressure
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 0, 1, 1, 1, 4'b0100, 0);
        add(0, 4'b0000, 1, 1, 1, 2, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0011, 0, 0, 0, 0, 4'b0011, 0);   // overflow
        add(0, 4'b0010, 0, 1, 1, 0, 4'b0010, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 4'b0010, 1);
        add(0, 4'b0000, 1, 1, 1, 1, 4'b0000, 1);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1);
        add(0, 4'b1011, 0, 0, 0, 0, 4'b1011, 1);   // reset mid-PRESENT
        add(0, 4'b0000, 0, 1, 1, 0, 4'b1010, 1);
        add(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0);
        add(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0);   // set wins over take
        add(0, 4'b0100, 0, 1, 1, 2, 4'b0100, 0);
        add(0, 4'b0000, 1, 1, 1, 2, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 1, 0, 4'b0000, 0);   // reset dominates req

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; req = tbl[i].req; out_ready = tbl[i].rdy;
            @(posedge clk); #1;
            check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            check($sformatf("row%0d pending", i), 64'(pending), 64'(tbl[i].ep));
            check($sformatf("row%0d overflow", i), 64'(overflow), 64'(tbl[i].eo));
            if (tbl[i].ci) begin
                check($sformatf("row%0d out_index", i), 64'(out_index), 64'(tbl[i].ei));
            end
        end

        // Latency from a single pulse, bounded wait.
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        @(posedge clk); #1;
        req = '0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency cycles", 64'(cyc), 64'd2);
        check("latency index", 64'(out_index), 64'd3);
        @(posedge clk); #1;
        check("latency single beat", 64'(out_valid), 64'd0);
`else
        // Saturated round robin: 1,2,3,0,1,... with no early repeat.
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rr first edge valid", 64'(out_valid), 64'd0);
        n_seen  = 0;
        exp_idx = 1;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                check($sformatf("rr beat%0d index", n_seen), 64'(out_index), 64'(exp_idx));
                exp_idx = (exp_idx + 1) % 4;
                n_seen++;
            end
        end
        check("rr beats seen", 64'(n_seen), 64'd11);
        @(negedge clk);
        req = '0;
        repeat (6) @(posedge clk);
        #1;
        check("rr drains", 64'(out_valid), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
